// File: rtl/atm_pkg.sv
// Shared encodings for the ATM session controller, keypad front end and display.
// State, status, input-style, menu and transaction codes are fixed binary values.
package atm_pkg;

    typedef logic [3:0] state_t;
    typedef logic [3:0] status_t;
    typedef logic [3:0] style_t;

    localparam state_t S_IDLE      = 4'd0;
    localparam state_t S_ACC_NUM   = 4'd1;
    localparam state_t S_PIN_INPUT = 4'd2;
    localparam state_t S_LOCKED    = 4'd3;
    localparam state_t S_MENU      = 4'd4;
    localparam state_t S_BALANCE   = 4'd5;
    localparam state_t S_CONV_SRC  = 4'd6;
    localparam state_t S_CONV_AMT  = 4'd7;
    localparam state_t S_CONV_DST  = 4'd8;
    localparam state_t S_WD_CUR    = 4'd9;
    localparam state_t S_WD_AMT    = 4'd10;
    localparam state_t S_XFER_ACC  = 4'd11;
    localparam state_t S_XFER_CUR  = 4'd12;
    localparam state_t S_XFER_AMT  = 4'd13;
    localparam state_t S_ERROR     = 4'd14;
    localparam state_t S_SUCCESS   = 4'd15;

    // Code 0 never arrives from the front end; it stands for "no qualified status".
    localparam status_t STAT_NONE           = 4'd0;
    localparam status_t STAT_ACC_FOUND      = 4'd1;
    localparam status_t STAT_ACC_NOT_FOUND  = 4'd2;
    localparam status_t STAT_PIN_CORRECT    = 4'd3;
    localparam status_t STAT_PIN_INCORRECT  = 4'd4;
    localparam status_t STAT_AMT_VALID      = 4'd5;
    localparam status_t STAT_AMT_INVALID    = 4'd6;
    localparam status_t STAT_EXIT           = 4'd7;
    localparam status_t STAT_INPUT_COMPLETE = 4'd8;

    localparam style_t STYLE_SINGLE_KEY      = 4'd1;
    localparam style_t STYLE_ACC_NUMBER      = 4'd2;
    localparam style_t STYLE_PIN_NUMBER      = 4'd3;
    localparam style_t STYLE_MENU_SELECTION  = 4'd4;
    localparam style_t STYLE_CURRENCY_TYPE   = 4'd5;
    localparam style_t STYLE_CURRENCY_AMOUNT = 4'd6;

    localparam logic [1:0] MENU_BALANCE  = 2'd0;
    localparam logic [1:0] MENU_CONVERT  = 2'd1;
    localparam logic [1:0] MENU_WITHDRAW = 2'd2;
    localparam logic [1:0] MENU_TRANSFER = 2'd3;

    localparam logic [1:0] TXN_CONVERT  = 2'd0;
    localparam logic [1:0] TXN_WITHDRAW = 2'd1;
    localparam logic [1:0] TXN_TRANSFER = 2'd2;

    function automatic style_t style_of(input state_t s);
        case (s)
            S_ACC_NUM, S_XFER_ACC:                        style_of = STYLE_ACC_NUMBER;
            S_PIN_INPUT:                                  style_of = STYLE_PIN_NUMBER;
            S_MENU:                                       style_of = STYLE_MENU_SELECTION;
            S_CONV_SRC, S_CONV_DST, S_WD_CUR, S_XFER_CUR: style_of = STYLE_CURRENCY_TYPE;
            S_CONV_AMT, S_WD_AMT, S_XFER_AMT:             style_of = STYLE_CURRENCY_AMOUNT;
            default:                                      style_of = STYLE_SINGLE_KEY;
        endcase
    endfunction

endpackage

// File: rtl/atm_session_ctrl_session_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
// Shared by the inactivity timeout and the lockout interval.
module session_timer #(
    parameter int             W           = 4,
    parameter logic [W-1:0]   RESET_VALUE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: account, PIN, menu and per-currency transaction flows,
// with PIN lockout, inactivity timeout and a registered ledger commit pulse.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int  NUM_CUR        = 4,
    parameter int  MAX_PIN_TRIES  = 3,
    parameter int  TIMEOUT_CYCLES = 1_000_000,
    parameter int  LOCK_CYCLES    = 10_000_000,
    localparam int CUR_W          = (NUM_CUR > 2) ? $clog2(NUM_CUR) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             status_valid,
    input  logic [3:0]       status_code,
    input  logic             menu_valid,
    input  logic [1:0]       menu_sel,
    input  logic [CUR_W-1:0] cur_sel,
    output logic [3:0]       state_code,
    output logic [15:0]      state_led,
    output logic [3:0]       input_style,
    output logic             txn_valid,
    output logic [1:0]       txn_type,
    output logic [CUR_W-1:0] txn_src_cur,
    output logic [CUR_W-1:0] txn_dst_cur,
    output logic             lockout,
    output logic             timeout
);

    localparam int MAX_LOAD = (TIMEOUT_CYCLES > LOCK_CYCLES) ? TIMEOUT_CYCLES : LOCK_CYCLES;
    localparam int TMR_W    = $clog2(MAX_LOAD);
    localparam int TRY_W    = $clog2(MAX_PIN_TRIES + 1);

    // Loading N-1 makes the expiry cycle the N-th cycle after the load.
    localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LOAD    = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TRY_W-1:0] LAST_TRY     = TRY_W'(MAX_PIN_TRIES - 1);

    state_t             state, next_state;
    status_t            code;
    logic [TRY_W-1:0]   tries, tries_next;
    logic [CUR_W-1:0]   src, src_next;
    logic [CUR_W-1:0]   commit_dst;
    logic [1:0]         commit_type;
    logic               commit, timeout_hit;
    logic               event_hit, cur_ok, expired, tmr_load;
    logic [TMR_W-1:0]   tmr_value;

    assign code      = status_valid ? status_code : STAT_NONE;
    assign event_hit = status_valid || (menu_valid && state == S_MENU);
    assign cur_ok    = 32'(cur_sel) < NUM_CUR;

    // NOTE: every combinational output gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        next_state  = state;
        tries_next  = tries;
        src_next    = src;
        commit      = 1'b0;
        commit_type = txn_type;
        commit_dst  = src;
        timeout_hit = 1'b0;

        case (state)
            S_IDLE: begin
                if (code == STAT_INPUT_COMPLETE) next_state = S_ACC_NUM;
            end
            S_ACC_NUM: begin
                if (code == STAT_ACC_FOUND) begin
                    next_state = S_PIN_INPUT;
                    tries_next = '0;
                end else if (code == STAT_ACC_NOT_FOUND) begin
                    next_state = S_IDLE;
                end
            end
            S_PIN_INPUT: begin
                if (code == STAT_PIN_CORRECT) begin
                    next_state = S_MENU;
                    tries_next = '0;
                end else if (code == STAT_PIN_INCORRECT) begin
                    tries_next = tries + TRY_W'(1);
                    if (tries == LAST_TRY) next_state = S_LOCKED;
                end
            end
            S_LOCKED: begin
                if (expired) begin
                    next_state = S_IDLE;
                    tries_next = '0;
                end
            end
            S_MENU: begin
                if (menu_valid) begin
                    case (menu_sel)
                        MENU_BALANCE:  next_state = S_BALANCE;
                        MENU_CONVERT:  next_state = S_CONV_SRC;
                        MENU_WITHDRAW: next_state = S_WD_CUR;
                        default:       next_state = S_XFER_ACC;
                    endcase
                end else if (code == STAT_EXIT) begin
                    next_state = S_IDLE;
                end
            end
            S_CONV_SRC, S_WD_CUR, S_XFER_CUR: begin
                if (code == STAT_INPUT_COMPLETE) begin
                    if (!cur_ok) begin
                        next_state = S_ERROR;
                    end else begin
                        src_next   = cur_sel;
                        next_state = (state == S_CONV_SRC) ? S_CONV_AMT :
                                     (state == S_WD_CUR)   ? S_WD_AMT   : S_XFER_AMT;
                    end
                end else if (code == STAT_EXIT) begin
                    next_state = S_MENU;
                end
            end
            S_XFER_ACC: begin
                if (code == STAT_ACC_FOUND)          next_state = S_XFER_CUR;
                else if (code == STAT_ACC_NOT_FOUND) next_state = S_ERROR;
                else if (code == STAT_EXIT)          next_state = S_MENU;
            end
            S_CONV_AMT: begin
                if (code == STAT_AMT_VALID)        next_state = S_CONV_DST;
                else if (code == STAT_AMT_INVALID) next_state = S_ERROR;
                else if (code == STAT_EXIT)        next_state = S_MENU;
            end
            S_CONV_DST: begin
                if (code == STAT_INPUT_COMPLETE) begin
                    if (!cur_ok || cur_sel == src) begin
                        next_state = S_ERROR;
                    end else begin
                        next_state  = S_SUCCESS;
                        commit      = 1'b1;
                        commit_type = TXN_CONVERT;
                        commit_dst  = cur_sel;
                    end
                end else if (code == STAT_EXIT) begin
                    next_state = S_MENU;
                end
            end
            S_WD_AMT, S_XFER_AMT: begin
                if (code == STAT_AMT_VALID) begin
                    next_state  = S_SUCCESS;
                    commit      = 1'b1;
                    commit_type = (state == S_WD_AMT) ? TXN_WITHDRAW : TXN_TRANSFER;
                end else if (code == STAT_AMT_INVALID) begin
                    next_state = S_ERROR;
                end else if (code == STAT_EXIT) begin
                    next_state = S_MENU;
                end
            end
            default: begin
                if (code == STAT_EXIT) next_state = S_MENU;
            end
        endcase

        // An event in the expiry cycle keeps the session alive.
        if (state != S_IDLE && state != S_LOCKED && !event_hit && expired) begin
            next_state  = S_IDLE;
            tries_next  = '0;
            commit      = 1'b0;
            timeout_hit = 1'b1;
        end
    end

    assign tmr_load  = (next_state != state) || (event_hit && state != S_LOCKED);
    assign tmr_value = (next_state == S_LOCKED) ? LOCK_LOAD : TIMEOUT_LOAD;

    session_timer #(
        .W           (TMR_W),
        .RESET_VALUE (TIMEOUT_LOAD)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (tmr_load),
        .load_value (tmr_value),
        .expired    (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            state_led   <= 16'h0001;
            input_style <= STYLE_SINGLE_KEY;
            tries       <= '0;
            src         <= '0;
            txn_valid   <= 1'b0;
            txn_type    <= TXN_CONVERT;
            txn_src_cur <= '0;
            txn_dst_cur <= '0;
            lockout     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= next_state;
            state_led   <= 16'd1 << next_state;
            input_style <= style_of(next_state);
            tries       <= tries_next;
            src         <= src_next;
            txn_valid   <= commit;
            lockout     <= (next_state == S_LOCKED);
            timeout     <= timeout_hit;
            if (commit) begin
                txn_type    <= commit_type;
                txn_src_cur <= src;
                txn_dst_cur <= commit_dst;
            end
        end
    end

    assign state_code = state;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: directed flows plus random traffic checked
// against a session-level reference model held in the bench.
module tb_atm_session_ctrl;

    localparam int NUM_CUR = 3;
    localparam int MAX_TRY = 3;
    localparam int TMO     = 16;
    localparam int LCK     = 8;
    localparam int CUR_W   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             status_valid = 1'b0;
    logic [3:0]       status_code = '0;
    logic             menu_valid = 1'b0;
    logic [1:0]       menu_sel = '0;
    logic [CUR_W-1:0] cur_sel = '0;
    logic [3:0]       state_code;
    logic [15:0]      state_led;
    logic [3:0]       input_style;
    logic             txn_valid;
    logic [1:0]       txn_type;
    logic [CUR_W-1:0] txn_src_cur, txn_dst_cur;
    logic             lockout, timeout;

    atm_session_ctrl #(
        .NUM_CUR(NUM_CUR), .MAX_PIN_TRIES(MAX_TRY),
        .TIMEOUT_CYCLES(TMO), .LOCK_CYCLES(LCK)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .status_valid(status_valid), .status_code(status_code),
        .menu_valid(menu_valid), .menu_sel(menu_sel), .cur_sel(cur_sel),
        .state_code(state_code), .state_led(state_led), .input_style(input_style),
        .txn_valid(txn_valid), .txn_type(txn_type),
        .txn_src_cur(txn_src_cur), .txn_dst_cur(txn_dst_cur),
        .lockout(lockout), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st; bit tv; int tt; int ts; int td; bit lk; bit to;
    } exp_t;
    typedef struct { int tt; int ts; int td; } txn_t;

    exp_t exp_q [$];
    txn_t txn_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Input style per state number, straight from the display table.
    int style_tab [0:15] = '{1, 2, 3, 1, 4, 1, 5, 6, 5, 5, 6, 2, 5, 6, 1, 1};

    // Reference model: session position plus elapsed-cycle counters.
    int m_st, m_tries, m_idle, m_lock, m_src, m_tt, m_ts, m_td;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_tries = 0; m_idle = 0; m_lock = 0;
        m_src = 0; m_tt = 0; m_ts = 0; m_td = 0;
    endtask

    task automatic model_step(input bit sv, input int sc, input bit mv, input int ms, input int cs);
        int  code, nst;
        bit  ev, commit, to, cur_ok;
        exp_t e;
        code   = sv ? sc : 0;
        ev     = sv || (mv && m_st == 4);
        nst    = m_st;
        commit = 0;
        to     = 0;
        cur_ok = cs < NUM_CUR;
        case (m_st)
            0: if (code == 8) nst = 1;
            1: if (code == 1) begin nst = 2; m_tries = 0; end
               else if (code == 2) nst = 0;
            2: if (code == 3) begin nst = 4; m_tries = 0; end
               else if (code == 4) begin
                   m_tries++;
                   if (m_tries >= MAX_TRY) nst = 3;
               end
            3: ;
            4: if (mv) nst = (ms == 0) ? 5 : (ms == 1) ? 6 : (ms == 2) ? 9 : 11;
               else if (code == 7) nst = 0;
            6, 9, 12: if (code == 8) begin
                   if (!cur_ok) nst = 14;
                   else begin m_src = cs; nst = m_st + 1; end
               end else if (code == 7) nst = 4;
            7: if (code == 5) nst = 8; else if (code == 6) nst = 14; else if (code == 7) nst = 4;
            8: if (code == 8) begin
                   if (!cur_ok || cs == m_src) nst = 14;
                   else begin
                       nst = 15; commit = 1; m_tt = 0; m_ts = m_src; m_td = cs;
                   end
               end else if (code == 7) nst = 4;
            10, 13: if (code == 5) begin
                   nst = 15; commit = 1; m_tt = (m_st == 10) ? 1 : 2; m_ts = m_src; m_td = m_src;
               end else if (code == 6) nst = 14;
               else if (code == 7) nst = 4;
            11: if (code == 1) nst = 12; else if (code == 2) nst = 14; else if (code == 7) nst = 4;
            default: if (code == 7) nst = 4;
        endcase
        if (m_st == 3) begin
            m_lock++;
            if (m_lock == LCK) begin nst = 0; m_tries = 0; end
        end else if (m_st != 0) begin
            if (ev) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TMO) begin nst = 0; m_tries = 0; to = 1; end
            end
        end
        if (nst != m_st) begin m_idle = 0; m_lock = 0; end
        m_st = nst;
        e.st = m_st; e.tv = commit; e.tt = m_tt; e.ts = m_ts; e.td = m_td;
        e.lk = (m_st == 3); e.to = to;
        exp_q.push_back(e);
        if (commit) txn_q.push_back('{m_tt, m_ts, m_td});
    endtask

    task automatic step(input bit sv, input int sc, input bit mv, input int ms, input int cs);
        @(negedge clk);
        status_valid = sv;
        status_code  = 4'(sc);
        menu_valid   = mv;
        menu_sel     = 2'(ms);
        cur_sel      = CUR_W'(cs);
        model_step(sv, sc, mv, ms, cs);
    endtask

    task automatic stat(input int sc, input int cs = 0);
        step(1, sc, 0, 0, cs);
    endtask

    task automatic menu(input int ms);
        step(0, 0, 1, ms, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_code), 32'd0);
        check({tag, "_led"},   32'(state_led), 32'h0001);
        check({tag, "_style"}, 32'(input_style), 32'd1);
        check({tag, "_txn_valid"}, 32'(txn_valid), 32'd0);
        check({tag, "_txn_type"},  32'(txn_type), 32'd0);
        check({tag, "_lockout"},   32'(lockout), 32'd0);
        check({tag, "_timeout"},   32'(timeout), 32'd0);
    endtask

    // Monitor: one expected snapshot per modelled cycle, one expected record per commit.
    initial begin
        exp_t e;
        txn_t t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("state_code",  32'(state_code),  32'(e.st));
                check("state_led",   32'(state_led),   32'd1 << e.st);
                check("input_style", 32'(input_style), 32'(style_tab[e.st]));
                check("txn_valid",   32'(txn_valid),   32'(e.tv));
                check("txn_type",    32'(txn_type),    32'(e.tt));
                check("txn_src_cur", 32'(txn_src_cur), 32'(e.ts));
                check("txn_dst_cur", 32'(txn_dst_cur), 32'(e.td));
                check("lockout",     32'(lockout),     32'(e.lk));
                check("timeout",     32'(timeout),     32'(e.to));
            end
            if (rst_n && txn_valid) begin
                if (txn_q.size() == 0) begin
                    check("txn_spurious", 32'(txn_valid), 32'd0);
                end else begin
                    t = txn_q.pop_front();
                    check("commit_type", 32'(txn_type),    32'(t.tt));
                    check("commit_src",  32'(txn_src_cur), 32'(t.ts));
                    check("commit_dst",  32'(txn_dst_cur), 32'(t.td));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #13;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Happy withdraw, then leave SUCCESS.
        stat(8); stat(1); stat(3); menu(2); stat(8, 1); stat(5); idle(1); stat(7);
        stat(7);

        // Three wrong PINs lock the session; inputs in LOCKED are ignored.
        stat(8); stat(1); stat(4); stat(4); stat(4);
        for (int i = 0; i < LCK; i++) stat((i % 8) + 1, 1);
        idle(1);
        stat(8); stat(1); stat(4); stat(4); stat(3);

        // Convert: same src/dst is an error, distinct currencies commit.
        menu(1); stat(8, 2); stat(5); stat(8, 2); stat(7);
        menu(1); stat(8, 2); stat(5); stat(8, 0); stat(7);

        // Timeout in XFER_CUR; an ignored code in cycle 16 still counts as activity.
        menu(3); stat(1); idle(TMO - 1); stat(2); idle(TMO); idle(1);

        // Qualification and priority.
        step(0, 8, 0, 0, 0);
        stat(8); stat(1); stat(3);
        step(1, 7, 1, 3, 0);
        stat(1); stat(8, 3); stat(7);
        menu(2); stat(8, 1);

        // Asynchronous reset mid-cycle while in WD_AMT.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        status_valid = 1'b0; menu_valid = 1'b0;
        #1;
        check_reset_outputs("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with occasional unqualified idle stretches.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                repeat ($urandom_range(12, 20))
                    step(0, $urandom_range(0, 15), 0, $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                step($urandom_range(0, 99) < 65,
                     ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 8),
                     $urandom_range(0, 99) < 30,
                     $urandom_range(0, 3),
                     $urandom_range(0, 3));
            end
        end
        idle(2);

        @(posedge clk);
        #2;
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        check("txn_queue_drained", 32'(txn_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Parametrised ATM session controller. It is the next-generation replacement for the single-clock ATM menu state machine. It sequences account entry, PIN entry, menu and transaction flows for NUM_CUR currencies. Compared with its predecessor it adds qualified (valid-strobed) inputs, a PIN-retry lockout, an inactivity timeout, a source/destination currency check and a registered transaction-commit pulse to the ledger logic downstream. It sits between the keypad/verification front end and the display/ledger back end.

## Interface
- NUM_CUR, 4: number of currencies; ≥2. CUR_W = max(1, $clog2(NUM_CUR)).
- MAX_PIN_TRIES, 3: consecutive PIN_INCORRECT responses that cause lockout; ≥1.
- TIMEOUT_CYCLES, 1_000_000: idle cycles before a session is aborted; ≥2.
- LOCK_CYCLES, 10_000_000: cycles spent in LOCKED; ≥2.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- status_valid  in  1  qualifies status_code for one cycle.
- status_code  in  4  1 ACC_FOUND, 2 ACC_NOT_FOUND, 3 PIN_CORRECT, 4 PIN_INCORRECT, 5 AMT_VALID, 6 AMT_INVALID, 7 EXIT, 8 INPUT_COMPLETE.
- menu_valid  in  1  qualifies menu_sel; honoured only in MENU.
- menu_sel  in  2  0 BALANCE, 1 CONVERT, 2 WITHDRAW, 3 TRANSFER.
- cur_sel  in  CUR_W  currency index; sampled on INPUT_COMPLETE in currency states.
- state_code  out  4  binary state.
- state_led  out  16  one-hot, 1<<state_code.
- input_style  out  4  1 SINGLE_KEY, 2 ACC_NUMBER, 3 PIN_NUMBER, 4 MENU_SELECTION, 5 CURRENCY_TYPE, 6 CURRENCY_AMOUNT.
- txn_valid  out  1  one-cycle commit pulse.
- txn_type  out  2  0 convert, 1 withdraw, 2 transfer; held until the next commit.
- txn_src_cur / txn_dst_cur  out  CUR_W  currencies of the committed transaction (dst = src for withdraw and transfer).
- lockout  out  1  high while in LOCKED.
- timeout  out  1  one-cycle pulse on a timeout abort.

## Operation
- States and codes: IDLE 0, ACC_NUM 1, PIN_INPUT 2, LOCKED 3, MENU 4, BALANCE 5, CONV_SRC 6, CONV_AMT 7, CONV_DST 8, WD_CUR 9, WD_AMT 10, XFER_ACC 11, XFER_CUR 12, XFER_AMT 13, ERROR 14, SUCCESS 15.
- Event = status_valid, or menu_valid while in MENU. With no event, the state holds. Codes not listed for the current state are ignored.
- IDLE: INPUT_COMPLETE → ACC_NUM.
- ACC_NUM: ACC_FOUND → PIN_INPUT (tries cleared to 0); ACC_NOT_FOUND → IDLE.
- PIN_INPUT: PIN_CORRECT → MENU, tries cleared. PIN_INCORRECT increments tries; the MAX_PIN_TRIES-th one → LOCKED, any earlier one stays in PIN_INPUT.
- LOCKED: all inputs ignored; after LOCK_CYCLES cycles → IDLE, tries cleared.
- MENU: menu_valid → BALANCE / CONV_SRC / WD_CUR / XFER_ACC per menu_sel. menu_valid takes priority over a simultaneous status EXIT. EXIT alone → IDLE.
- CONV_SRC, WD_CUR, XFER_CUR: INPUT_COMPLETE captures cur_sel as src, then → CONV_AMT / WD_AMT / XFER_AMT. If cur_sel ≥ NUM_CUR → ERROR instead.
- XFER_ACC: ACC_FOUND → XFER_CUR; ACC_NOT_FOUND → ERROR.
- CONV_AMT: AMT_VALID → CONV_DST; AMT_INVALID → ERROR.
- CONV_DST: INPUT_COMPLETE with cur_sel equal to src, or cur_sel ≥ NUM_CUR → ERROR. Otherwise capture dst → SUCCESS.
- WD_AMT, XFER_AMT: AMT_VALID → SUCCESS; AMT_INVALID → ERROR.
- EXIT in any transaction state, BALANCE, ERROR or SUCCESS → MENU.
- input_style by state:
  - SINGLE_KEY: IDLE, LOCKED, BALANCE, ERROR, SUCCESS.
  - ACC_NUMBER: ACC_NUM, XFER_ACC.
  - PIN_NUMBER: PIN_INPUT.
  - MENU_SELECTION: MENU.
  - CURRENCY_TYPE: CONV_SRC, CONV_DST, WD_CUR, XFER_CUR.
  - CURRENCY_AMOUNT: *_AMT.
- Inactivity: in every state except IDLE and LOCKED, the counter reloads on each event and on every state change. On expiry → IDLE, tries cleared, timeout pulses. If an event and expiry fall in the same cycle, the event wins.

## Timing
- All outputs are registered (Moore). A qualifying event in cycle N is reflected in every output at cycle N+1.
- txn_valid is high exactly in the first cycle of SUCCESS, and the txn_* fields are valid in that same cycle.
- Timeout fires after TIMEOUT_CYCLES consecutive event-free cycles in the same state. LOCKED lasts exactly LOCK_CYCLES cycles.
- Reset (asynchronous assert, synchronous deassert upstream): state IDLE, state_code 0, state_led 16'h0001, input_style 1, tries 0, counter reloaded, all other outputs 0.
- Reset mid-transaction aborts without a commit pulse.

## Structure
- Package atm_pkg holds the state enum, status codes, input styles, menu codes and txn types. It is shared with the front end and the display.
- Sub-module session_timer: a loadable down-counter with a load value, load strobe and expiry flag. One instance serves both the timeout and lockout functions, because LOCKED excludes timeout.

## Test plan
Bench parameters: NUM_CUR=3, MAX_PIN_TRIES=3, TIMEOUT_CYCLES=16, LOCK_CYCLES=8.
- Happy withdraw: IDLE, INPUT_COMPLETE, ACC_FOUND, PIN_CORRECT, menu 2, cur_sel=1 + INPUT_COMPLETE, AMT_VALID → SUCCESS at state_code 15, with txn_valid one cycle and txn_type=1, src=dst=1.
- Lockout: 3× PIN_INCORRECT → LOCKED, lockout=1, input ignored for 8 cycles, then IDLE. Same flow with 2× incorrect then PIN_CORRECT → MENU.
- Convert: src=2, AMT_VALID, dst=2 → ERROR with no txn_valid. Retry with dst=0 → SUCCESS, txn_type=0, src=2, dst=0.
- Timeout: idle in XFER_CUR for 16 cycles → IDLE with a single timeout pulse. An event on cycle 16 instead keeps the session alive.
- Qualification and priority: status_code=EXIT with status_valid=0 → no change. In MENU, menu_valid with sel 3 plus EXIT in the same cycle → XFER_ACC. cur_sel=3 → ERROR.
- Async reset asserted in WD_AMT mid-cycle → immediate IDLE, state_led=1, input_style=1, txn_valid=0.
